// File: rtl/framebuffer_writer.sv
`default_nettype none
// ============================================================================
// Module      : framebuffer_writer
// Description : Final write stage in front of the dual-bank 1-bit framebuffer
//               RAM. Merges pixel writes from sample_to_pixel with a hardware
//               zero-fill sweep and double-buffers the two banks so the
//               display never scans the bank being drawn into. Each frame
//               start swaps banks, then clears the new write bank while
//               clearing_framebuffer is held high.
// Ports       :
//   clk                  in   system clock (only clock of the block)
//   reset                in   synchronous, active-high reset
//   frame_pulse          in   frame start from the pixel-clock domain (async)
//   pixel_addr           in   pixel address from sample_to_pixel
//   pixel_data           in   pixel value from sample_to_pixel
//   pixel_wr_en          in   pixel write strobe from sample_to_pixel
//   fb_wr_addr           out  RAM write address {write_bank, addr}
//   fb_wr_data           out  RAM write data
//   fb_wr_en             out  RAM write enable
//   clearing_framebuffer out  high while a swap or clear is in progress
//   display_bank         out  bank scanned by the display (write bank = ~it)
//   frame_overrun        out  sticky: frame edge arrived with a clear pending
// Revision    : 1.0 - initial release
// ============================================================================
module framebuffer_writer #(
   parameter int SCREEN_WIDTH  = 640,
   parameter int SCREEN_HEIGHT = 480,
   parameter int ADDR_WIDTH    = $clog2(SCREEN_WIDTH * SCREEN_HEIGHT)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  frame_pulse,
   input  logic [ADDR_WIDTH-1:0] pixel_addr,
   input  logic                  pixel_data,
   input  logic                  pixel_wr_en,
   output logic [ADDR_WIDTH:0]   fb_wr_addr,
   output logic                  fb_wr_data,
   output logic                  fb_wr_en,
   output logic                  clearing_framebuffer,
   output logic                  display_bank,
   output logic                  frame_overrun
);

   localparam int                    NUM_PIXELS = SCREEN_WIDTH * SCREEN_HEIGHT;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(NUM_PIXELS - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SWAP  = 2'd1,
      ST_CLEAR = 2'd2
   } state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] clear_addr;
   logic                  pending;
   // [0],[1]: two-flop synchronizer; [2]: previous value for edge detection
   logic [2:0]            frame_sync;
   logic                  frame_edge;

   assign frame_edge = frame_sync[1] & ~frame_sync[2];

   always_ff @(posedge clk) begin
      if (reset) begin
         frame_sync           <= 3'b000;
         state                <= ST_CLEAR;
         clear_addr           <= '0;
         pending              <= 1'b0;
         display_bank         <= 1'b1;
         fb_wr_en             <= 1'b0;
         fb_wr_data           <= 1'b0;
         fb_wr_addr           <= '0;
         frame_overrun        <= 1'b0;
         clearing_framebuffer <= 1'b1;
      end else begin
         frame_sync           <= {frame_sync[1:0], frame_pulse};
         clearing_framebuffer <= (state != ST_IDLE);

         // Single write port: pixel writes always win, the sweep takes
         // whatever cycles are left over.
         if (pixel_wr_en) begin
            fb_wr_en   <= 1'b1;
            fb_wr_addr <= {~display_bank, pixel_addr};
            fb_wr_data <= pixel_data;
         end else if (state == ST_CLEAR) begin
            fb_wr_en   <= 1'b1;
            fb_wr_addr <= {~display_bank, clear_addr};
            fb_wr_data <= 1'b0;
         end else begin
            fb_wr_en   <= 1'b0;
         end

         case (state)
            ST_IDLE: begin
               if (frame_edge) begin
                  state <= ST_SWAP;
               end
            end

            ST_SWAP: begin
               display_bank <= ~display_bank;
               clear_addr   <= '0;
               state        <= ST_CLEAR;
               if (frame_edge) begin
                  pending       <= 1'b1;
                  frame_overrun <= 1'b1;
               end
            end

            ST_CLEAR: begin
               if (frame_edge) begin
                  pending       <= 1'b1;
                  frame_overrun <= 1'b1;
               end
               if (!pixel_wr_en) begin
                  if (clear_addr == LAST_ADDR) begin
                     // An edge landing on the final write still queues a
                     // frame, so it is folded into the decision here.
                     if (pending || frame_edge) begin
                        pending <= 1'b0;
                        state   <= ST_SWAP;
                     end else begin
                        state   <= ST_IDLE;
                     end
                  end else begin
                     clear_addr <= clear_addr + ADDR_WIDTH'(1);
                  end
               end
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_framebuffer_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_framebuffer_writer
// Description : Self-checking bench for framebuffer_writer (8x4 screen).
//               A job-level reference model predicts every RAM write, the
//               displayed bank, the clearing flag and the overrun flag; a set
//               of directed scenarios is followed by randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_framebuffer_writer;

   localparam int SW     = 8;
   localparam int SH     = 4;
   localparam int AW     = 5;
   localparam int NPIX   = SW * SH;

   logic          clk = 1'b0;
   logic          reset;
   logic          frame_pulse;
   logic [AW-1:0] pixel_addr;
   logic          pixel_data;
   logic          pixel_wr_en;
   logic [AW:0]   fb_wr_addr;
   logic          fb_wr_data;
   logic          fb_wr_en;
   logic          clearing_framebuffer;
   logic          display_bank;
   logic          frame_overrun;

   framebuffer_writer #(
      .SCREEN_WIDTH (SW),
      .SCREEN_HEIGHT(SH),
      .ADDR_WIDTH   (AW)
   ) dut (
      .clk                 (clk),
      .reset               (reset),
      .frame_pulse         (frame_pulse),
      .pixel_addr          (pixel_addr),
      .pixel_data          (pixel_data),
      .pixel_wr_en         (pixel_wr_en),
      .fb_wr_addr          (fb_wr_addr),
      .fb_wr_data          (fb_wr_data),
      .fb_wr_en            (fb_wr_en),
      .clearing_framebuffer(clearing_framebuffer),
      .display_bank        (display_bank),
      .frame_overrun       (frame_overrun)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------
   // Reference model: a clear "job" is a count of zero writes still owed
   // to the write bank; at most one further frame may be queued behind it.
   // ------------------------------------------------------------------
   logic [2:0]  m_sync;
   bit          m_bank;
   bit          m_swap;      // bank swap owed on the next cycle
   int          m_left;      // clear writes still owed in current job
   int          m_next;      // next address the job will zero
   bit          m_queued;
   bit          m_overrun;
   bit          exp_en;
   logic [AW:0] exp_addr;
   bit          exp_data;
   bit          exp_clearing;
   bit          exp_full;    // addr/data must also match while en is low
   int          cyc = 0;

   always @(posedge clk) begin : p_model
      bit fe;
      cyc++;
      fe = m_sync[1] & ~m_sync[2];
      if (reset) begin
         m_sync = 3'b000; m_bank = 1'b1; m_swap = 1'b0; m_left = NPIX; m_next = 0;
         m_queued = 1'b0; m_overrun = 1'b0;
         exp_en = 1'b0; exp_addr = '0; exp_data = 1'b0; exp_clearing = 1'b1; exp_full = 1'b1;
      end else begin
         exp_full     = 1'b0;
         exp_clearing = m_swap || (m_left > 0);
         if (pixel_wr_en) begin
            exp_en = 1'b1; exp_addr = {~m_bank, pixel_addr}; exp_data = pixel_data;
         end else if (m_left > 0) begin
            exp_en = 1'b1; exp_addr = {~m_bank, AW'(m_next)}; exp_data = 1'b0;
         end else begin
            exp_en = 1'b0;
         end
         if (fe && (m_swap || m_left > 0)) begin
            m_queued  = 1'b1;
            m_overrun = 1'b1;
         end
         if (m_swap) begin
            m_swap = 1'b0; m_bank = ~m_bank; m_left = NPIX; m_next = 0;
         end else if (m_left > 0) begin
            if (!pixel_wr_en) begin
               m_left--;
               m_next++;
               if (m_left == 0 && m_queued) begin
                  m_queued = 1'b0;
                  m_swap   = 1'b1;
               end
            end
         end else if (fe) begin
            m_swap = 1'b1;
         end
         m_sync = {m_sync[1:0], frame_pulse};
      end
   end

   // ------------------------------------------------------------------
   // Per-cycle comparison and event counters, sampled on the falling edge
   // ------------------------------------------------------------------
   bit chk_on   = 1'b0;
   int wr_cnt   = 0;
   int tog_cnt  = 0;
   int tog_cyc  = -1;
   bit prev_bank = 1'b1;

   always @(negedge clk) begin
      if (chk_on) begin
         check_eq("wr_en", fb_wr_en, exp_en);
         if (exp_en || exp_full) begin
            check_eq("wr_addr", fb_wr_addr, exp_addr);
            check_eq("wr_data", fb_wr_data, exp_data);
         end
         check_eq("display_bank", display_bank, m_bank);
         check_eq("clearing", clearing_framebuffer, exp_clearing);
         check_eq("overrun", frame_overrun, m_overrun);
         if (fb_wr_en === 1'b1) wr_cnt++;
         if (display_bank !== prev_bank) begin
            tog_cnt++;
            if (tog_cyc < 0) tog_cyc = cyc;
         end
         prev_bank = display_bank;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int rise_cyc;
      int pulse_left;
      int k;
      reset = 1'b1; frame_pulse = 1'b0; pixel_addr = '0; pixel_data = 1'b0; pixel_wr_en = 1'b0;
      tick(2);
      chk_on = 1'b1;
      check_eq("reset_bank", display_bank, 1);
      check_eq("reset_clearing", clearing_framebuffer, 1);
      check_eq("reset_wr_en", fb_wr_en, 0);

      // 1: startup sweep of bank 0, no pixel traffic
      reset = 1'b0; wr_cnt = 0; tog_cnt = 0;
      tick(40);
      check_eq("s1_clear_writes", wr_cnt, 32);
      check_eq("s1_toggles", tog_cnt, 0);
      check_eq("s1_idle", clearing_framebuffer, 0);

      // 2: one wide frame pulse from idle
      wr_cnt = 0; tog_cnt = 0; tog_cyc = -1; rise_cyc = cyc;
      frame_pulse = 1'b1; tick(4); frame_pulse = 1'b0;
      tick(45);
      check_eq("s2_clear_writes", wr_cnt, 32);
      check_eq("s2_toggles", tog_cnt, 1);
      check_eq("s2_toggle_latency", (tog_cyc - rise_cyc >= 3) && (tog_cyc - rise_cyc <= 4), 1);
      check_eq("s2_bank", display_bank, 0);

      // 3: clear interleaved with a pixel write every other cycle
      wr_cnt = 0;
      frame_pulse = 1'b1; tick(1); frame_pulse = 1'b0;
      for (int i = 0; i < 80; i++) begin
         pixel_wr_en = (i % 2 == 1); pixel_addr = 5'd5; pixel_data = 1'b1;
         tick(1);
      end
      pixel_wr_en = 1'b0;
      tick(10);
      check_eq("s3_total_writes", wr_cnt, 72);
      check_eq("s3_bank", display_bank, 1);

      // 4: two frame edges within one clear
      tog_cnt = 0;
      check_eq("s4_overrun_before", frame_overrun, 0);
      frame_pulse = 1'b1; tick(2); frame_pulse = 1'b0;
      tick(10);
      check_eq("s4_overrun_after_first", frame_overrun, 0);
      frame_pulse = 1'b1; tick(2); frame_pulse = 1'b0;
      tick(4);
      check_eq("s4_overrun_after_second", frame_overrun, 1);
      tick(90);
      check_eq("s4_toggles", tog_cnt, 2);
      check_eq("s4_idle", clearing_framebuffer, 0);

      // 5: reset in the middle of a bank-1 clear
      frame_pulse = 1'b1; tick(1); frame_pulse = 1'b0;
      k = 0;
      while (k < 100 && !(m_left > 0 && !m_swap && m_next == 17)) begin
         tick(1);
         k++;
      end
      check_eq("s5_pre_reset_addr", fb_wr_addr, {1'b1, 5'd16});
      reset = 1'b1; tick(1);
      check_eq("s5_no_write", fb_wr_en, 0);
      check_eq("s5_bank", display_bank, 1);
      reset = 1'b0; wr_cnt = 0;
      tick(40);
      check_eq("s5_restart_writes", wr_cnt, 32);

      // 6: 100 back-to-back pixel writes while idle
      wr_cnt = 0;
      for (int i = 0; i < 100; i++) begin
         pixel_wr_en = 1'b1;
         pixel_addr  = AW'($urandom_range(0, NPIX - 1));
         pixel_data  = 1'($urandom_range(0, 1));
         tick(1);
      end
      pixel_wr_en = 1'b0;
      tick(3);
      check_eq("s6_pixel_writes", wr_cnt, 100);

      // 7: randomized traffic, frame pulses and occasional resets
      pulse_left = 0;
      for (int i = 0; i < 3000; i++) begin
         pixel_wr_en = ($urandom_range(0, 2) == 0);
         pixel_addr  = AW'($urandom_range(0, NPIX - 1));
         pixel_data  = 1'($urandom_range(0, 1));
         if (pulse_left > 0) begin
            pulse_left--;
            frame_pulse = (pulse_left > 0);
         end else if ($urandom_range(0, 39) == 0) begin
            pulse_left  = $urandom_range(1, 4);
            frame_pulse = 1'b1;
         end else begin
            frame_pulse = 1'b0;
         end
         reset = ($urandom_range(0, 799) == 0);
         tick(1);
      end
      reset = 1'b0; pixel_wr_en = 1'b0; frame_pulse = 1'b0;
      tick(5);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
